// File: rtl/sysid_checker_pkg.sv
// sysid_checker_pkg: shared FSM state type, Avalon word addresses and default expected sysid values
package sysid_checker_pkg;
  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_e;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam logic [31:0] SYSID_DEFAULT_ID = 32'd1800062834;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1308259129;
  localparam int unsigned SYSID_TIMER_W = 16;
endpackage

// File: rtl/sysid_wait_timer.sv
// sysid_wait_timer: waitrequest stall counter; clr zeroes it, en counts a stall cycle, tc flags the stall that reaches LIMIT
module sysid_wait_timer
  import sysid_checker_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [SYSID_TIMER_W-1:0] cnt_q, cnt_d;
  // tc fires on the stall cycle that would bring the count to LIMIT
  assign tc = en && (cnt_q == SYSID_TIMER_W'(LIMIT - 1));
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master reading sysid ID (addr 0) and timestamp (addr 1) and flagging matches; SYSID_CHECKER_TIMEOUT_EN adds a stall timeout
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_word,
  output logic [31:0] ts_word,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout
);
  state_e      state_q, state_d;
  logic [31:0] id_word_q, id_word_d, ts_word_q, ts_word_d;
  logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;
  logic        tmo;
`ifdef SYSID_CHECKER_TIMEOUT_EN
  // counter restarts whenever a read state is entered and idles at zero elsewhere
  sysid_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_d != state_q) || !avm_read),
    .en    (avm_read && avm_waitrequest),
    .tc    (tmo)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  assign avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
  assign avm_address = (state_q == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy        = avm_read || (state_q == CHECK);
  assign done        = state_q == DONE;
  assign id_word     = id_word_q;
  assign ts_word     = ts_word_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  always_comb begin
    state_d   = state_q;
    id_word_d = id_word_q;
    ts_word_d = ts_word_q;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: state_d = RD_ID;
      RD_ID: begin
        // a completing read takes priority over a simultaneous terminal count
        if (!avm_waitrequest) begin
          id_word_d = avm_readdata;
          state_d   = RD_TS;
        end else if (tmo) begin
          timeout_d = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          state_d   = DONE;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          ts_word_d = avm_readdata;
          state_d   = CHECK;
        end else if (tmo) begin
          timeout_d = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          state_d   = DONE;
        end
      end
      CHECK: begin
        id_ok_d = id_word_q == EXPECTED_ID;
        ts_ok_d = ts_word_q == EXPECTED_TS;
        state_d = DONE;
      end
      DONE: begin
        if (start) begin
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = RD_ID;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      id_word_q <= '0;
      ts_word_q <= '0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_word_q <= id_word_d;
      ts_word_q <= ts_word_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      timeout_q <= timeout_d;
    end
  end
endmodule
